// File: rtl/case_1_mul_pkg.sv
// Shared encodings and range helpers for the handshaked pipelined multiplier.
package case_1_mul_pkg;

    // Output reduction modes
    localparam int MUL_WRAP = 0;
    localparam int MUL_SAT  = 1;

    // Largest representable value of a w-bit result (w <= 64), in the low w bits
    function automatic logic [63:0] mul_max(input int unsigned w, input bit is_signed);
        logic [63:0] one;
        one = 64'd1;
        if (is_signed)
            return (one << (w - 1)) - one;
        else if (w >= 64)
            return '1;
        else
            return (one << w) - one;
    endfunction

    // Smallest representable value of a w-bit result, in the low w bits
    function automatic logic [63:0] mul_min(input int unsigned w, input bit is_signed);
        if (is_signed)
            return ~mul_max(w, 1'b1);
        else
            return '0;
    endfunction

endpackage

// File: rtl/case_1_mul_pipe_stage.sv
// One valid+data register slice of the multiplier pipe. A slice accepts new
// content whenever it is empty or its current content moves on downstream,
// so bubbles collapse and a full pipe still streams at one entry per cycle.
module case_1_mul_pipe_stage #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         ce_i,
    input  logic         valid_i,
    input  logic [W-1:0] data_i,
    input  logic         next_ready_i,
    output logic         ready_o,
    output logic         valid_o,
    output logic [W-1:0] data_o
);

    logic         v_q, v_d;
    logic [W-1:0] d_q, d_d;

    // Combinational ready; chains back from the consumer through every slice
    assign ready_o = ce_i && (!v_q || next_ready_i);
    assign valid_o = v_q;
    assign data_o  = d_q;

    // Next state: take upstream content when ready, data only on a real entry
    always_comb begin
        v_d = v_q;
        d_d = d_q;
        if (ready_o) begin
            v_d = valid_i;
            if (valid_i)
                d_d = data_i;
        end
    end

    // State registers, cleared asynchronously
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            v_q <= 1'b0;
            d_q <= '0;
        end else begin
            v_q <= v_d;
            d_q <= d_d;
        end
    end

endmodule

// File: rtl/case_1_mul_pipe_hs.sv
// Pipelined valid/ready integer multiplier. The full product is formed ahead
// of the first slice, carried unchanged through the pipe, and reduced to the
// output width (wrap or saturate, with overflow flag) after the last slice.
module case_1_mul_pipe_hs
    import case_1_mul_pkg::*;
#(
    parameter int ID          = 1,
    parameter int NUM_STAGE   = 3,
    parameter int din0_WIDTH  = 14,
    parameter int din1_WIDTH  = 12,
    parameter int dout_WIDTH  = 26,
    parameter int din0_SIGNED = 1,
    parameter int din1_SIGNED = 1,
    parameter int SAT_MODE    = MUL_WRAP
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  ce,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [din0_WIDTH-1:0] din0,
    input  logic [din1_WIDTH-1:0] din1,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [dout_WIDTH-1:0] dout,
    output logic                  ovf,
    output logic                  busy
);

    localparam int P       = din0_WIDTH + din1_WIDTH;
    localparam bit PSIGNED = (din0_SIGNED != 0) || (din1_SIGNED != 0);

    localparam logic [63:0] SAT_MAX64 = mul_max(dout_WIDTH, PSIGNED);
    localparam logic [63:0] SAT_MIN64 = mul_min(dout_WIDTH, PSIGNED);
    localparam logic [dout_WIDTH-1:0] SAT_MAX = SAT_MAX64[dout_WIDTH-1:0];
    localparam logic [dout_WIDTH-1:0] SAT_MIN = SAT_MIN64[dout_WIDTH-1:0];

    // Operands get one extra bit so an unsigned operand stays non-negative
    // in a signed multiply; the exact product then always fits in P bits.
    logic signed [din0_WIDTH:0] a_ext;
    logic signed [din1_WIDTH:0] b_ext;
    logic signed [P-1:0]        a_p, b_p, prod;

    assign a_ext = {(din0_SIGNED != 0) & din0[din0_WIDTH-1], din0};
    assign b_ext = {(din1_SIGNED != 0) & din1[din1_WIDTH-1], din1};
    assign a_p   = P'(a_ext);
    assign b_p   = P'(b_ext);
    assign prod  = a_p * b_p;

    // Pipe of NUM_STAGE slices carrying the full product
    logic [NUM_STAGE-1:0]        v, rdy, nrdy;
    logic [NUM_STAGE-1:0][P-1:0] d;

    for (genvar k = 0; k < NUM_STAGE; k++) begin : g_stage
        logic         vin;
        logic [P-1:0] din;

        if (k == 0) begin : g_head
            assign vin = in_valid;
            assign din = prod;
        end else begin : g_body
            assign vin = v[k-1];
            assign din = d[k-1];
        end

        if (k == NUM_STAGE - 1) begin : g_tail
            assign nrdy[k] = out_ready;
        end else begin : g_mid
            assign nrdy[k] = rdy[k+1];
        end

        case_1_mul_pipe_stage #(.W(P)) u_stage (
            .clk          (clk),
            .reset        (reset),
            .ce_i         (ce),
            .valid_i      (vin),
            .data_i       (din),
            .next_ready_i (nrdy[k]),
            .ready_o      (rdy[k]),
            .valid_o      (v[k]),
            .data_o       (d[k])
        );
    end

    assign in_ready  = rdy[0];
    assign out_valid = v[NUM_STAGE-1];
    assign busy      = |v;

    // Output reduction from the last slice's full product
    logic [P-1:0]          last_q;
    logic [dout_WIDTH-1:0] dout_c;
    logic                  ovf_c;

    assign last_q = d[NUM_STAGE-1];

    if (dout_WIDTH >= P) begin : g_extend
        // Result is wide enough: extend only, never overflows
        always_comb begin
            dout_c = PSIGNED ? dout_WIDTH'($signed(last_q)) : dout_WIDTH'(last_q);
        end
        assign ovf_c = 1'b0;
    end else begin : g_reduce
        logic [dout_WIDTH-1:0]   low;
        logic [P-dout_WIDTH-1:0] drop;
        logic                    lost;

        // Keep low bits; flag lost magnitude and clamp it when saturating
        always_comb begin
            low  = last_q[dout_WIDTH-1:0];
            drop = last_q[P-1:dout_WIDTH];
            if (PSIGNED)
                lost = (drop != {(P-dout_WIDTH){low[dout_WIDTH-1]}});
            else
                lost = (drop != '0);
            dout_c = low;
            if (lost && (SAT_MODE == MUL_SAT))
                dout_c = (PSIGNED && last_q[P-1]) ? SAT_MIN : SAT_MAX;
        end
        assign ovf_c = lost;
    end

    assign dout = dout_c;
    assign ovf  = ovf_c;

endmodule

// File: tb/tb_case_1_mul_pipe_hs.sv
// Self-checking bench for the handshaked pipelined multiplier.
module tb_case_1_mul_pipe_hs;

    logic clk = 1'b0;
    logic reset, ce;
    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h expected=%0h", name, got, exp);
        end
    endtask

    // Behavioural model: exact integer product, then fit into dw bits
    function automatic void model(input logic [63:0] a_raw, input logic [63:0] b_raw,
                                  input int w0, input int w1, input int dw,
                                  input bit s0, input bit s1, input bit sat,
                                  output logic [63:0] r, output bit o);
        longint one, a, b, p, mx, mn, res;
        one = 1;
        a = longint'(a_raw) & ((one << w0) - 1);
        b = longint'(b_raw) & ((one << w1) - 1);
        if (s0 && ((a >> (w0 - 1)) & 1) == 1) a = a - (one << w0);
        if (s1 && ((b >> (w1 - 1)) & 1) == 1) b = b - (one << w1);
        p = a * b;
        if (s0 || s1) begin
            mx = (one << (dw - 1)) - 1;
            mn = -(one << (dw - 1));
        end else begin
            mx = (one << dw) - 1;
            mn = 0;
        end
        o = 0;
        res = p;
        if (dw < w0 + w1 && (p > mx || p < mn)) begin
            o = 1;
            if (sat) res = (p > mx) ? mx : mn;
        end
        r = 64'(res) & ((64'd1 << dw) - 64'd1);
    endfunction

    // ---------------- main DUT (defaults) ----------------
    logic        in_valid, in_ready, out_valid, out_ready, ovf, busy;
    logic [13:0] din0;
    logic [11:0] din1;
    logic [25:0] dout;

    case_1_mul_pipe_hs dut (
        .clk(clk), .reset(reset), .ce(ce),
        .in_valid(in_valid), .in_ready(in_ready), .din0(din0), .din1(din1),
        .out_valid(out_valid), .out_ready(out_ready), .dout(dout), .ovf(ovf), .busy(busy)
    );

    // ---------------- narrow DUTs: saturate / wrap ----------------
    logic       s_valid, s_oready;
    logic [6:0] s_a;
    logic [4:0] s_b;
    logic       sat_ir, sat_ov, sat_ovf, sat_busy;
    logic [6:0] sat_d;
    logic       wrp_ir, wrp_ov, wrp_ovf, wrp_busy;
    logic [6:0] wrp_d;

    case_1_mul_pipe_hs #(.din0_WIDTH(7), .din1_WIDTH(5), .dout_WIDTH(7), .SAT_MODE(1)) u_sat (
        .clk(clk), .reset(reset), .ce(ce),
        .in_valid(s_valid), .in_ready(sat_ir), .din0(s_a), .din1(s_b),
        .out_valid(sat_ov), .out_ready(s_oready), .dout(sat_d), .ovf(sat_ovf), .busy(sat_busy)
    );

    case_1_mul_pipe_hs #(.din0_WIDTH(7), .din1_WIDTH(5), .dout_WIDTH(7), .SAT_MODE(0)) u_wrp (
        .clk(clk), .reset(reset), .ce(ce),
        .in_valid(s_valid), .in_ready(wrp_ir), .din0(s_a), .din1(s_b),
        .out_valid(wrp_ov), .out_ready(s_oready), .dout(wrp_d), .ovf(wrp_ovf), .busy(wrp_busy)
    );

    // ---------------- unsigned-operand-0 DUT ----------------
    logic        u_valid;
    logic [13:0] u_a;
    logic [11:0] u_b;
    logic        uns_ir, uns_ov, uns_ovf, uns_busy;
    logic [25:0] uns_d;

    case_1_mul_pipe_hs #(.din0_SIGNED(0)) u_uns (
        .clk(clk), .reset(reset), .ce(ce),
        .in_valid(u_valid), .in_ready(uns_ir), .din0(u_a), .din1(u_b),
        .out_valid(uns_ov), .out_ready(s_oready), .dout(uns_d), .ovf(uns_ovf), .busy(uns_busy)
    );

    // ---------------- scoreboard for the main DUT ----------------
    typedef struct { logic [25:0] d; logic o; } exp_t;
    exp_t q[$];
    int   pops = 0;

    bit          have_prev = 0;
    logic        prev_ce, prev_ov, prev_or, prev_ovf, prev_busy;
    logic [25:0] prev_d;

    // Every cycle: handshake-level rules, hold rules, then ordered results
    always @(negedge clk) begin
        logic [63:0] r;
        bit          o;
        exp_t        e;
        if (reset) begin
            have_prev = 0;
        end else begin
            chk("in_ready_rule", in_ready, ce && (q.size() < 3 || out_ready));
            chk("busy_rule", busy, q.size() != 0);
            if (have_prev && !prev_ce) begin
                chk("ce_hold_valid", out_valid, prev_ov);
                chk("ce_hold_dout", dout, prev_d);
                chk("ce_hold_ovf", ovf, prev_ovf);
                chk("ce_hold_busy", busy, prev_busy);
            end else if (have_prev && prev_ov && !prev_or) begin
                chk("stall_valid", out_valid, 1'b1);
                chk("stall_dout", dout, prev_d);
                chk("stall_ovf", ovf, prev_ovf);
            end
            if (ce && out_valid && out_ready) begin
                if (q.size() == 0) begin
                    chk("unexpected_output", 1'b1, 1'b0);
                end else begin
                    e = q.pop_front();
                    chk("stream_dout", dout, e.d);
                    chk("stream_ovf", ovf, e.o);
                end
                pops++;
            end
            if (in_valid && in_ready) begin
                model(64'(din0), 64'(din1), 14, 12, 26, 1, 1, 0, r, o);
                e.d = r[25:0];
                e.o = o;
                q.push_back(e);
            end
            have_prev = 1;
            prev_ce   = ce;
            prev_ov   = out_valid;
            prev_or   = out_ready;
            prev_d    = dout;
            prev_ovf  = ovf;
            prev_busy = busy;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Offer vectors with backpressure handled; returns accept count
    task automatic offer(input int ncyc, input logic [13:0] va[8], input logic [11:0] vb[8],
                         inout int idx, output int acc);
        bit took;
        acc = 0;
        for (int c = 0; c < ncyc && idx < 8; c++) begin
            in_valid = 1'b1;
            din0 = va[idx];
            din1 = vb[idx];
            @(negedge clk);
            took = in_ready;
            tick();
            if (took) begin
                idx++;
                acc++;
            end
        end
        in_valid = 1'b0;
    endtask

    initial begin
        logic [13:0] va[8];
        logic [11:0] vb[8];
        logic [63:0] r;
        bit          o;
        int          idx, acc, p0;

        reset = 1'b1; ce = 1'b1;
        in_valid = 0; out_ready = 1; din0 = '0; din1 = '0;
        s_valid = 0; s_oready = 1; s_a = '0; s_b = '0;
        u_valid = 0; u_a = '0; u_b = '0;

        // Reset state
        #12;
        chk("rst_out_valid", out_valid, 1'b0);
        chk("rst_dout", dout, 26'h0);
        chk("rst_ovf", ovf, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_in_ready", in_ready, 1'b1);
        @(posedge clk); #3;
        reset = 1'b0;
        tick();

        // Single operation, exact latency: (-5) x 3 = -15
        in_valid = 1; din0 = 14'h3FFB; din1 = 12'h003;
        tick();
        in_valid = 0;
        @(negedge clk); chk("lat_c1_valid", out_valid, 1'b0);
        @(negedge clk); chk("lat_c2_valid", out_valid, 1'b0);
        @(negedge clk);
        chk("lat_c3_valid", out_valid, 1'b1);
        chk("lat_c3_dout", dout, 26'h3FFFFF1);
        chk("lat_c3_ovf", ovf, 1'b0);
        tick();
        repeat (3) tick();

        // Back-to-back stream of 20 random pairs at full rate
        p0 = pops;
        for (int i = 0; i < 20; i++) begin
            in_valid = 1;
            din0 = 14'($urandom);
            din1 = 12'($urandom);
            @(negedge clk);
            chk("stream_accept", in_ready, 1'b1);
            tick();
        end
        in_valid = 0;
        repeat (6) tick();
        chk("stream_count", pops - p0, 20);

        // Backpressure: 6 stalled cycles take exactly 3, then drain all 8
        for (int i = 0; i < 8; i++) begin
            va[i] = 14'($urandom);
            vb[i] = 12'($urandom);
        end
        va[0] = 14'h2000; vb[0] = 12'h800;   // most negative x most negative
        p0 = pops; idx = 0;
        out_ready = 0;
        offer(6, va, vb, idx, acc);
        chk("bp_accepted", acc, 3);
        @(negedge clk);
        chk("bp_in_ready_low", in_ready, 1'b0);
        tick();
        out_ready = 1;
        offer(40, va, vb, idx, acc);
        chk("bp_all_in", idx, 8);
        repeat (6) tick();
        chk("bp_count", pops - p0, 8);

        // ce low for 2 cycles mid-stream
        p0 = pops;
        for (int i = 0; i < 8; i++) begin
            va[i] = 14'($urandom);
            vb[i] = 12'($urandom);
        end
        idx = 0;
        offer(3, va, vb, idx, acc);
        ce = 0;
        in_valid = 1; din0 = va[idx]; din1 = vb[idx];
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            chk("ce_low_in_ready", in_ready, 1'b0);
            tick();
        end
        ce = 1;
        offer(20, va, vb, idx, acc);
        repeat (6) tick();
        chk("ce_count", pops - p0, 8);

        // Asynchronous reset with 2 entries in flight
        out_ready = 0;
        idx = 0;
        offer(2, va, vb, idx, acc);
        @(posedge clk); #3;
        chk("pre_rst_busy", busy, 1'b1);
        reset = 1;
        #1;
        chk("async_rst_valid", out_valid, 1'b0);
        chk("async_rst_busy", busy, 1'b0);
        q.delete();
        @(posedge clk); #3;
        reset = 0;
        out_ready = 1;
        p0 = pops;
        in_valid = 1; din0 = 14'h0007; din1 = 12'h009;
        tick();
        in_valid = 0;
        repeat (8) tick();
        chk("post_rst_count", pops - p0, 1);

        // Narrow widths: saturate vs wrap, plus unsigned operand 0
        chk("narrow_idle_ready", sat_ir & wrp_ir & uns_ir, 1'b1);
        s_valid = 1; s_a = 7'h40; s_b = 5'h10;          // (-64) x (-16)
        u_valid = 1; u_a = 14'h3FFF; u_b = 12'hFFF;     // 16383 x (-1)
        tick();
        s_a = 7'h05; s_b = 5'h1D;                        // 5 x (-3)
        u_valid = 0;
        tick();
        s_valid = 0;
        @(negedge clk);
        @(negedge clk);
        chk("sat1_valid", sat_ov, 1'b1);
        chk("sat1_dout", sat_d, 7'h3F);
        chk("sat1_ovf", sat_ovf, 1'b1);
        chk("wrp1_dout", wrp_d, 7'h00);
        chk("wrp1_ovf", wrp_ovf, 1'b1);
        model(64'h40, 64'h10, 7, 5, 7, 1, 1, 1, r, o);
        chk("sat1_model", {sat_ovf, sat_d}, {o, r[6:0]});
        model(64'h40, 64'h10, 7, 5, 7, 1, 1, 0, r, o);
        chk("wrp1_model", {wrp_ovf, wrp_d}, {o, r[6:0]});
        chk("uns_valid", uns_ov, 1'b1);
        chk("uns_dout", uns_d, 26'h3FFC001);
        chk("uns_ovf", uns_ovf, 1'b0);
        model(64'h3FFF, 64'hFFF, 14, 12, 26, 0, 1, 0, r, o);
        chk("uns_model", uns_d, r[25:0]);
        @(negedge clk);
        chk("sat2_dout", sat_d, 7'h71);
        chk("sat2_ovf", sat_ovf, 1'b0);
        chk("wrp2_dout", wrp_d, 7'h71);
        chk("wrp2_ovf", wrp_ovf, 1'b0);
        repeat (4) tick();
        chk("narrow_drained", sat_busy | wrp_busy | uns_busy, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
